uart_bpsk_endpoint: RTL and testbench

Receive-side endpoint of the digital transceiver. It contains three independent datapaths that share one clock and reset:
- an 8N1 UART receiver (host byte in);
- an 8N1 UART transmitter (host byte out);
- a BPSK demodulator that turns sine-referenced sample streams back into DATA_WIDTH-bit Hamming codewords.

It sits between the serial host pins and the Hamming encoder/modulator/decoder chain.

---
 rtl/uart_bpsk_endpoint_if.sv | 25 ++
 rtl/uart_bpsk_endpoint.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_bpsk_endpoint.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bpsk_endpoint_if.sv
// Host-side bundle of the endpoint: UART byte handshakes and demodulated word.
interface uart_bpsk_endpoint_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  rx_dv;
    logic [7:0]            rx_byte;
    logic                  tx_dv;
    logic [7:0]            tx_byte;
    logic                  tx_active;
    logic                  tx_done;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;

    // Host side: requests transmissions, consumes received bytes and words.
    modport master (
        output tx_dv, tx_byte,
        input  rx_dv, rx_byte, tx_active, tx_done, q, q_valid
    );

    // Endpoint side.
    modport slave (
        input  tx_dv, tx_byte,
        output rx_dv, rx_byte, tx_active, tx_done, q, q_valid
    );
endinterface

// File: rtl/uart_bpsk_endpoint.sv
// Receive-side endpoint: 8N1 UART RX, 8N1 UART TX and a BPSK symbol demodulator.
// The three datapaths are independent and share only clk and the sync reset.
module uart_bpsk_endpoint #(
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned SAMPLE_NUMBER = 256,
    parameter int unsigned SAMPLE_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH    = 12
) (
    input  logic                             clk,
    input  logic                             arstn,
    input  logic                             rx_serial,
    output logic                             tx_serial,
    input  logic                             en,
    input  logic [SAMPLE_WIDTH-1:0]          signal_in,
    input  logic [SAMPLE_WIDTH-1:0]          sin_in,
    input  logic [SAMPLE_WIDTH-1:0]          neg_sin_in,
    input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
    uart_bpsk_endpoint_if.slave              bus
);

    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF   = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned PH_W   = $clog2(SAMPLE_NUMBER);
    localparam int unsigned BC_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned DIFF_W = SAMPLE_WIDTH + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF);
    localparam logic [PH_W-1:0]  PEAK_IDX  = PH_W'(SAMPLE_NUMBER / 4);
    localparam logic [BC_W-1:0]  WORD_LAST = BC_W'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------ UART RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             rx_dv_r, rx_dv_nxt;
    logic [7:0]       rx_byte_r, rx_byte_nxt;

    // Two-flop synchronizer on the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (arstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clk) begin
        if (arstn) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_dv_r   <= 1'b0;
            rx_byte_r <= '0;
        end else begin
            rx_state  <= rx_state_nxt;
            rx_cnt    <= rx_cnt_nxt;
            rx_bit    <= rx_bit_nxt;
            rx_shift  <= rx_shift_nxt;
            rx_dv_r   <= rx_dv_nxt;
            rx_byte_r <= rx_byte_nxt;
        end
    end

    // RX next state: centre on the start bit, then sample once per bit period.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_dv_nxt    = 1'b0;
        rx_byte_nxt  = rx_byte_r;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                rx_bit_nxt = '0;
                if (!rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_bit_nxt   = '0;
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_sync) begin
                        rx_byte_nxt = rx_shift;
                        rx_dv_nxt   = 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign bus.rx_dv   = rx_dv_r;
    assign bus.rx_byte = rx_byte_r;

    // ------------------------------------------------------------------ UART TX
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic             tx_serial_r, tx_serial_nxt;
    logic             tx_active_r, tx_active_nxt;
    logic             tx_done_r, tx_done_nxt;

    // TX state and line registers.
    always_ff @(posedge clk) begin
        if (arstn) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_serial_r <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            tx_state    <= tx_state_nxt;
            tx_cnt      <= tx_cnt_nxt;
            tx_bit      <= tx_bit_nxt;
            tx_shift    <= tx_shift_nxt;
            tx_serial_r <= tx_serial_nxt;
            tx_active_r <= tx_active_nxt;
            tx_done_r   <= tx_done_nxt;
        end
    end

    // TX next state: the line value for each bit is registered on entry to it.
    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt;
        tx_bit_nxt    = tx_bit;
        tx_shift_nxt  = tx_shift;
        tx_serial_nxt = tx_serial_r;
        tx_active_nxt = tx_active_r;
        tx_done_nxt   = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_serial_nxt = 1'b1;
                tx_active_nxt = 1'b0;
                tx_cnt_nxt    = '0;
                tx_bit_nxt    = '0;
                if (bus.tx_dv) begin
                    tx_shift_nxt  = bus.tx_byte;
                    tx_serial_nxt = 1'b0;
                    tx_active_nxt = 1'b1;
                    tx_state_nxt  = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt    = '0;
                    tx_serial_nxt = tx_shift[0];
                    tx_state_nxt  = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_bit_nxt    = '0;
                        tx_serial_nxt = 1'b1;
                        tx_state_nxt  = TX_STOP;
                    end else begin
                        tx_bit_nxt    = tx_bit + 3'd1;
                        tx_shift_nxt  = {1'b0, tx_shift[7:1]};
                        tx_serial_nxt = tx_shift[1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt    = '0;
                    tx_active_nxt = 1'b0;
                    tx_done_nxt   = 1'b1;
                    tx_state_nxt  = TX_DONE;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_DONE: begin
                tx_serial_nxt = 1'b1;
                tx_state_nxt  = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    assign tx_serial     = tx_serial_r;
    assign bus.tx_active = tx_active_r;
    assign bus.tx_done   = tx_done_r;

    // ------------------------------------------------------------ BPSK demod
    logic [DIFF_W-1:0]     sig_x, sin_x, neg_x, dp, dn;
    logic                  dm_bit_c;
    logic [DATA_WIDTH-1:0] dm_shift, dm_shift_nxt;
    logic [BC_W-1:0]       dm_cnt, dm_cnt_nxt;
    logic [DATA_WIDTH-1:0] q_r, q_nxt;
    logic                  q_valid_r, q_valid_nxt;

    // Distance of the received sample to each reference; ties favour the sine.
    always_comb begin
        sig_x    = DIFF_W'(signal_in);
        sin_x    = DIFF_W'(sin_in);
        neg_x    = DIFF_W'(neg_sin_in);
        dp       = (sig_x >= sin_x) ? (sig_x - sin_x) : (sin_x - sig_x);
        dn       = (sig_x >= neg_x) ? (sig_x - neg_x) : (neg_x - sig_x);
        dm_bit_c = (dp <= dn);
    end

    // Demodulator next state: one decision per reference period at the sine peak.
    always_comb begin
        dm_shift_nxt = dm_shift;
        dm_cnt_nxt   = dm_cnt;
        q_nxt        = q_r;
        q_valid_nxt  = 1'b0;
        if (en && (cnt_in == PEAK_IDX)) begin
            dm_shift_nxt = {dm_shift[DATA_WIDTH-2:0], dm_bit_c};
            if (dm_cnt == WORD_LAST) begin
                dm_cnt_nxt  = '0;
                q_nxt       = dm_shift_nxt;
                q_valid_nxt = 1'b1;
            end else begin
                dm_cnt_nxt = dm_cnt + BC_W'(1);
            end
        end
    end

    // Demodulator registers.
    always_ff @(posedge clk) begin
        if (arstn) begin
            dm_shift  <= '0;
            dm_cnt    <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else begin
            dm_shift  <= dm_shift_nxt;
            dm_cnt    <= dm_cnt_nxt;
            q_r       <= q_nxt;
            q_valid_r <= q_valid_nxt;
        end
    end

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;

endmodule

// File: tb/tb_uart_bpsk_endpoint.sv
// Scoreboard bench for uart_bpsk_endpoint: RX, TX, loopback and demodulator.
module tb_uart_bpsk_endpoint;

    localparam int unsigned CPB  = 8;
    localparam int unsigned SN   = 64;
    localparam int unsigned SW   = 12;
    localparam int unsigned DW   = 12;
    localparam int unsigned PW   = $clog2(SN);
    localparam int          HALF = (CPB - 1) / 2;
    localparam int          NOM  = HALF + 9 * CPB + 3;

    logic          clk;
    logic          arstn;
    logic          rx_drv;
    logic          loop;
    logic          rx_serial;
    logic          tx_serial;
    logic          en;
    logic [SW-1:0] signal_in, sin_in, neg_sin_in;
    logic [PW-1:0] cnt_in;

    uart_bpsk_endpoint_if #(.DATA_WIDTH(DW)) bus ();

    uart_bpsk_endpoint #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_NUMBER(SN),
        .SAMPLE_WIDTH (SW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .rx_serial (rx_serial),
        .tx_serial (tx_serial),
        .en        (en),
        .signal_in (signal_in),
        .sin_in    (sin_in),
        .neg_sin_in(neg_sin_in),
        .cnt_in    (cnt_in),
        .bus       (bus)
    );

    assign rx_serial = loop ? tx_serial : rx_drv;

    always #5 clk = ~clk;

    int n_vec;
    int n_miscmp;
    int cyc;
    int done_cnt;
    int act_len;

    logic [7:0]    rx_exp_q[$];
    int            rx_t_q[$];
    logic [DW-1:0] q_exp_q[$];
    int            q_t_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RX and demodulator scoreboards, TX frame-length monitor.
    always @(negedge clk) begin
        if (!arstn) begin
            if (bus.rx_dv) begin
                if (rx_exp_q.size() == 0) chk("rx_unexpected_dv", 1, 0);
                else begin
                    int t;
                    chk("rx_byte", 32'(bus.rx_byte), 32'(rx_exp_q.pop_front()));
                    t = rx_t_q.pop_front();
                    chk("rx_latency_in_window",
                        32'((cyc - t >= NOM - 1) && (cyc - t <= NOM + 1)), 1);
                end
            end
            if (bus.q_valid) begin
                if (q_exp_q.size() == 0) chk("q_unexpected_valid", 1, 0);
                else begin
                    chk("q_word", 32'(bus.q), 32'(q_exp_q.pop_front()));
                    chk("q_timing", 32'(cyc), 32'(q_t_q.pop_front()));
                end
            end
            if (bus.tx_active) act_len++;
            else if (act_len != 0) begin
                chk("tx_frame_len", 32'(act_len), 10 * CPB);
                act_len = 0;
            end
            if (bus.tx_done) begin
                done_cnt++;
                chk("tx_done_active_low", 32'(bus.tx_active), 0);
            end
        end
    end

    function automatic logic [SW-1:0] sine(input int k, input bit neg);
        real v;
        int  s;
        v = 2000.0 * $sin(2.0 * 3.141592653589793 * real'(k) / real'(SN));
        s = neg ? 2048 - $rtoi(v) : 2048 + $rtoi(v);
        return SW'(s);
    endfunction

    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fb;
        fb = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rx_drv = fb[i];
            if (i == 0 && stop_ok) begin
                rx_exp_q.push_back(b);
                rx_t_q.push_back(cyc);
            end
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk); #1 rx_drv = 1'b1;
        repeat (3 * CPB) @(posedge clk);
    endtask

    task automatic tx_send(input logic [7:0] b, input bit check_line);
        logic [9:0] fb;
        int d0, t;
        fb = {1'b1, b, 1'b0};
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.tx_dv = 1'b1;
        bus.tx_byte = b;
        @(posedge clk); #1;
        bus.tx_dv = 1'b0;
        if (loop) begin
            rx_exp_q.push_back(b);
            rx_t_q.push_back(cyc);
        end
        if (check_line) begin
            @(posedge clk); #1;
            chk("tx_active_after_accept", 32'(bus.tx_active), 1);
            chk("tx_start_low", 32'(tx_serial), 0);
            repeat (CPB / 2 - 1) @(posedge clk);
            #1;
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("tx_line_bit%0d", i), 32'(tx_serial), 32'(fb[i]));
                if (i == 4) begin
                    bus.tx_dv = 1'b1;
                    bus.tx_byte = ~b;
                end
                if (i < 9) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                end
                bus.tx_dv = 1'b0;
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 12 * CPB) begin
            @(posedge clk); #1;
            t++;
        end
        chk("tx_done_seen", 32'(done_cnt - d0), 1);
    endtask

    task automatic demod_word(input logic [DW-1:0] w, input int skip_sym);
        int  nsym, bi;
        logic b;
        bit  skipped;
        nsym = (skip_sym >= 0) ? DW + 1 : DW;
        bi = DW - 1;
        for (int s = 0; s < nsym; s++) begin
            skipped = (s == skip_sym);
            b = skipped ? ~w[bi] : w[bi];
            for (int k = 0; k < SN; k++) begin
                @(posedge clk); #1;
                cnt_in     = PW'(k);
                sin_in     = sine(k, 1'b0);
                neg_sin_in = sine(k, 1'b1);
                signal_in  = b ? sin_in : neg_sin_in;
                en         = !(skipped && k >= int'(SN / 4) - 2 && k <= int'(SN / 4) + 2);
                if (k == int'(SN / 4) && !skipped && bi == 0) begin
                    q_exp_q.push_back(w);
                    q_t_q.push_back(cyc + 1);
                end
            end
            if (!skipped) bi--;
        end
        @(posedge clk); #1 en = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        clk = 1'b0; arstn = 1'b1; rx_drv = 1'b1; loop = 1'b0;
        en = 1'b0; signal_in = '0; sin_in = '0; neg_sin_in = '0; cnt_in = '0;
        bus.tx_dv = 1'b0; bus.tx_byte = '0;
        n_vec = 0; n_miscmp = 0; cyc = 0; done_cnt = 0; act_len = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_serial", 32'(tx_serial), 1);
        chk("rst_tx_active", 32'(bus.tx_active), 0);
        chk("rst_tx_done", 32'(bus.tx_done), 0);
        chk("rst_rx_dv", 32'(bus.rx_dv), 0);
        chk("rst_rx_byte", 32'(bus.rx_byte), 0);
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_q_valid", 32'(bus.q_valid), 0);
        arstn = 1'b0;
        repeat (4) @(posedge clk);

        rx_frame(8'hA5, 1'b1);
        chk("rx_byte_held", 32'(bus.rx_byte), 32'h A5);

        @(posedge clk); #1 rx_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (3 * CPB) @(posedge clk);

        rx_frame(8'h3C, 1'b0);
        chk("rx_byte_after_framing_err", 32'(bus.rx_byte), 32'h A5);

        d0 = done_cnt;
        tx_send(8'h3C, 1'b1);
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("tx_no_second_frame", 32'(bus.tx_active), 0);
        chk("tx_single_done", 32'(done_cnt - d0), 1);
        chk("tx_idle_line", 32'(tx_serial), 1);

        loop = 1'b1;
        tx_send(8'h00, 1'b0);
        tx_send(8'hFF, 1'b0);
        tx_send(8'h5A, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        loop = 1'b0;

        demod_word(12'hB2D, -1);
        chk("q_held", 32'(bus.q), 32'h B2D);
        demod_word(12'h4D3, 5);
        chk("q_held_skip", 32'(bus.q), 32'h 4D3);

        repeat (10) @(posedge clk);
        chk("rx_scoreboard_drained", 32'(rx_exp_q.size()), 0);
        chk("q_scoreboard_drained", 32'(q_exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
